adc_responder: RTL and testbench

Synthesizable SPI ADC responder: the slave end of the chip-select/MISO link that the ADC capture block drives. It watches `cs`, serializes one 8-bit sample per frame onto `miso` in the serial-ADC frame format, and reports frame statistics. It runs on the fabric clock, so the design can be exercised on the board without the physical ADC or the image sensor. Sample data comes from an input port or from an internal ramp pattern.

---
 rtl/adc_responder.sv | 113 +++++++++++
 tb/tb_adc_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_responder.sv
// Serial-ADC slave model: answers the capture master's chip select with one
// 8-bit sample per frame on miso, and keeps completed-frame / abort statistics.
module adc_responder #(
    parameter int LEADING_ZEROS = 3,
    parameter int FRAME_LEN     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    output logic        miso,
    input  logic [7:0]  sample_in,
    input  logic        pattern_en,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  sample_q, sample_d;
    logic        pat_q, pat_d;
    logic [7:0]  ramp_q, ramp_d;
    logic        miso_d;
    logic        busy_d;
    logic [15:0] count_d;
    logic        err_d;

    // Bit k of the frame: leading zeros, data MSB first, then zero padding.
    function automatic logic frame_bit(input logic [7:0] s, input logic [5:0] k);
        int off;
        off = int'(k) - LEADING_ZEROS;
        if (off >= 0 && off < 8) return s[3'(7 - off)];
        return 1'b0;
    endfunction

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sample_d = sample_q;
        pat_d    = pat_q;
        ramp_d   = ramp_q;
        miso_d   = 1'b0;
        count_d  = frame_count;
        err_d    = frame_err;

        unique case (state_q)
            IDLE: begin
                if (!cs) begin
                    state_d  = SHIFT;
                    sample_d = pattern_en ? ramp_q : sample_in;
                    pat_d    = pattern_en;
                    bitcnt_d = '0;
                    miso_d   = frame_bit(sample_d, 6'd0);
                end
            end
            SHIFT: begin
                // The final edge completes the frame even if cs has just risen.
                if (bitcnt_q == 6'(FRAME_LEN - 1)) begin
                    state_d = DONE;
                    count_d = frame_count + 16'd1;
                    if (pat_q) ramp_d = ramp_q + 8'd1;
                end else if (cs) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    bitcnt_d = bitcnt_q + 6'd1;
                    miso_d   = frame_bit(sample_q, bitcnt_q + 6'd1);
                end
            end
            DONE: begin
                if (cs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            sample_q    <= '0;
            pat_q       <= 1'b0;
            ramp_q      <= '0;
            miso        <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
            frame_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            sample_q    <= sample_d;
            pat_q       <= pat_d;
            ramp_q      <= ramp_d;
            miso        <= miso_d;
            busy        <= busy_d;
            frame_count <= count_d;
            frame_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_adc_responder.sv
// Randomized scoreboard bench for adc_responder: a frame-level model predicts
// each frame's bits, length and statistics; a monitor compares on busy falling.
module tb_adc_responder;

    localparam int LZ        = 3;
    localparam int FRAME_LEN = 16;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        miso;
    logic [7:0]  sample_in;
    logic        pattern_en;
    logic        busy;
    logic [15:0] frame_count;
    logic        frame_err;

    adc_responder #(.LEADING_ZEROS(LZ), .FRAME_LEN(FRAME_LEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .miso       (miso),
        .sample_in  (sample_in),
        .pattern_en (pattern_en),
        .busy       (busy),
        .frame_count(frame_count),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bits;
        int          len;
        logic [15:0] cnt;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    bit          started = 0;

    logic [7:0]  m_ramp;
    logic [15:0] m_count;
    logic        m_err;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Whole frame as a FRAME_LEN-bit word, MSB = first bit on the wire.
    function automatic logic [31:0] frame_word(input logic [7:0] data);
        return 32'(data) << (FRAME_LEN - LZ - 8);
    endfunction

    // Monitor: collect miso while busy, compare the finished frame when busy drops.
    logic [31:0] got_bits = '0;
    int          got_len  = 0;
    always @(negedge clk) begin
        if (started) begin
            if (busy) begin
                got_bits = {got_bits[30:0], miso};
                got_len++;
            end else if (got_len > 0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got len %0d expected none", got_len);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("frame_len", 32'(got_len), 32'(e.len));
                    check("frame_bits", got_bits, e.bits);
                    check("frame_count", 32'(frame_count), 32'(e.cnt));
                    check("frame_err", 32'(frame_err), 32'(e.err));
                end
                got_len  = 0;
                got_bits = '0;
            end else begin
                check("idle_miso", 32'(miso), 32'd0);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset   = 1'b1;
        m_ramp  = '0;
        m_count = '0;
        m_err   = 1'b0;
        started = 1;
    endtask

    // One cs-low window of `low` edges then `idle` edges high. low >= FRAME_LEN
    // completes the frame; a shorter window aborts it after `low` bits.
    task automatic frame(input logic pat, input logic [7:0] smp, input int low,
                         input int idle, input int chg_at, input logic [7:0] chg_val);
        exp_t e;
        logic [7:0] data;
        int len;
        data = pat ? m_ramp : smp;
        if (low >= FRAME_LEN) begin
            len = FRAME_LEN;
            m_count++;
            if (pat) m_ramp++;
        end else begin
            len   = low;
            m_err = 1'b1;
        end
        e.bits = frame_word(data) >> (FRAME_LEN - len);
        e.len  = len;
        e.cnt  = m_count;
        e.err  = m_err;
        sb.push_back(e);
        cs         = 1'b0;
        pattern_en = pat;
        sample_in  = smp;
        for (int i = 0; i < low; i++) begin
            @(negedge clk);
            if (i == chg_at) sample_in = chg_val;
        end
        cs = 1'b1;
        for (int i = 0; i < idle; i++) @(negedge clk);
    endtask

    initial begin
        cs         = 1'b1;
        sample_in  = 8'h00;
        pattern_en = 1'b0;
        do_reset();
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(frame_count), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);

        // 0xA5 frame: 0,0,0,1,0,1,0,0,1,0,1,0,0,0,0,0
        frame(1'b0, 8'hA5, FRAME_LEN + 1, 1, -1, 8'h00);

        // Ramp across its wrap point.
        for (int i = 0; i < 258; i++) frame(1'b1, 8'h00, FRAME_LEN + 1, 1, -1, 8'h00);

        // Abort after E0+6, then a normal ramp frame proves ramp was untouched.
        frame(1'b1, 8'h00, 7, 2, -1, 8'h00);
        frame(1'b1, 8'h00, FRAME_LEN + 1, 1, -1, 8'h00);

        // cs held low long past the frame: exactly one frame.
        frame(1'b0, 8'hC3, 40, 1, -1, 8'h00);

        // sample_in changes mid-frame; the latched 0x3C must be sent.
        frame(1'b0, 8'h3C, FRAME_LEN + 1, 1, 3, 8'hFF);

        // Random mix of complete and aborted frames with mid-frame input changes.
        for (int i = 0; i < 60; i++) begin
            int low;
            if ($urandom_range(0, 3) == 0) low = $urandom_range(1, FRAME_LEN - 1);
            else                           low = $urandom_range(FRAME_LEN + 1, FRAME_LEN + 5);
            frame(1'($urandom_range(0, 1)), 8'($urandom), low, $urandom_range(1, 3),
                  $urandom_range(0, FRAME_LEN - 1), 8'($urandom));
        end

        // Reset mid-frame with frame_count = 5.
        do_reset();
        for (int i = 0; i < 5; i++) frame(1'b0, 8'($urandom), FRAME_LEN + 1, 1, -1, 8'h00);
        begin
            exp_t e;
            e.bits = frame_word(8'h96) >> (FRAME_LEN - 9);
            e.len  = 9;
            e.cnt  = 16'd0;
            e.err  = 1'b0;
            sb.push_back(e);
        end
        check("pre_reset_count", 32'(frame_count), 32'd5);
        cs         = 1'b0;
        sample_in  = 8'h96;
        pattern_en = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_miso", 32'(miso), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_count", 32'(frame_count), 32'd0);
        check("midrst_err", 32'(frame_err), 32'd0);
        reset   = 1'b1;
        m_ramp  = '0;
        m_count = '0;
        m_err   = 1'b0;
        // cs still low: a new frame must start on the first edge out of reset.
        frame(1'b0, 8'h5A, FRAME_LEN + 1, 3, -1, 8'h00);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
